window_gen: RTL



---
 rtl/window_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/window_gen.sv
// Streaming KxK sliding-window generator: raster pixels in, one window per channel
// for every valid (unpadded) output position out, with a 1-cycle registered latency.
module window_gen #(
    parameter int unsigned WidthIn     = 1,
    parameter int unsigned KernelWidth = 3,
    parameter int unsigned InChannels  = 2,
    parameter int unsigned ImageWidth  = 640,
    parameter int unsigned ImageHeight = 480,
    localparam int unsigned KernelArea = KernelWidth * KernelWidth
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic                                               valid_i,
    output logic                                               ready_o,
    input  logic [InChannels-1:0][WidthIn-1:0]                 data_i,
    output logic                                               valid_o,
    input  logic                                               ready_i,
    output logic [InChannels-1:0][KernelArea-1:0][WidthIn-1:0] windows_o,
    output logic                                               last_o
);

    localparam int unsigned ColW  = $clog2(ImageWidth);
    localparam int unsigned RowW  = $clog2(ImageHeight);
    localparam int unsigned Lines = KernelWidth - 1;

    localparam logic [ColW-1:0] ColLast  = ColW'(ImageWidth - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(ImageHeight - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(KernelWidth - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(KernelWidth - 1);

    typedef logic [WidthIn-1:0] sample_t;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            accept;

    sample_t win_q      [InChannels][KernelWidth][KernelWidth];
    sample_t win_d      [InChannels][KernelWidth][KernelWidth];
    sample_t lb_q       [InChannels][Lines][ImageWidth];
    sample_t lb_wdata_d [InChannels][Lines];
    sample_t col_vec    [InChannels][KernelWidth];

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;
    assign valid_o = valid_q;
    assign last_o  = last_q;

    // Next-state: counters, output flags, line-buffer write data and window shift.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q & ~ready_i;
        last_d  = last_q & ~ready_i;
        win_d   = win_q;

        // Column entering the window: buffered lines on top (oldest first), live pixel at the bottom.
        for (int unsigned ch = 0; ch < InChannels; ch++) begin
            for (int unsigned l = 0; l + 1 < Lines; l++) begin
                lb_wdata_d[ch][l] = lb_q[ch][l+1][col_q];
            end
            lb_wdata_d[ch][Lines-1] = data_i[ch];
            for (int unsigned r = 0; r < Lines; r++) begin
                col_vec[ch][r] = lb_q[ch][r][col_q];
            end
            col_vec[ch][Lines] = data_i[ch];
        end

        if (accept) begin
            for (int unsigned ch = 0; ch < InChannels; ch++) begin
                for (int unsigned r = 0; r < KernelWidth; r++) begin
                    for (int unsigned c = 0; c + 1 < KernelWidth; c++) begin
                        win_d[ch][r][c] = win_q[ch][r][c+1];
                    end
                    win_d[ch][r][KernelWidth-1] = col_vec[ch][r];
                end
            end

            valid_d = (col_q >= ColFirst) && (row_q >= RowFirst);
            last_d  = (col_q == ColLast) && (row_q == RowLast);

            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int unsigned ch = 0; ch < InChannels; ch++) begin
                for (int unsigned r = 0; r < KernelWidth; r++) begin
                    for (int unsigned c = 0; c < KernelWidth; c++) begin
                        win_q[ch][r][c] <= '0;
                    end
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    // Line buffers hold no reset; their contents only reach a valid window after refill.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int unsigned ch = 0; ch < InChannels; ch++) begin
                for (int unsigned l = 0; l < Lines; l++) begin
                    lb_q[ch][l][col_q] <= lb_wdata_d[ch][l];
                end
            end
        end
    end

    always_comb begin
        windows_o = '0;
        for (int unsigned ch = 0; ch < InChannels; ch++) begin
            for (int unsigned r = 0; r < KernelWidth; r++) begin
                for (int unsigned c = 0; c < KernelWidth; c++) begin
                    windows_o[ch][r*KernelWidth+c] = win_q[ch][r][c];
                end
            end
        end
    end

endmodule
